// File: rtl/pwm_multichannel.sv
// Multichannel PWM peripheral: shared period counter, per-channel compare with alignment/invert,
// shadowed configuration that loads at the period boundary. Optional period interrupt: PWM_IRQ_EN.
module pwm_multichannel #(
    parameter int          NCH       = 4,
    parameter int          CW        = 16,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     add,
    input  logic [31:0]     din,
    output logic [31:0]     dout,
    input  logic            wr,
    input  logic            rd,
    output logic            wr_busy,
    output logic            rd_busy,
    input  logic            wr_strobe,
    input  logic            rd_strobe,
    input  logic [3:0]      mask,
    output logic [NCH-1:0]  pwm_out,
    output logic            irq
);

    localparam logic [CW-1:0] PERIOD_RST = CW'(99);

    // Bus handshake: a request is accepted in IDLE when add is inside the window (wr beats rd);
    // busy rises on the next edge and drops on the edge after the matching master strobe.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_WAIT = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    state_t state, next_state;

    logic        in_window, wr_start, rd_start, commit;
    logic [7:0]  lat_off;
    logic [31:0] lat_din;
    logic [3:0]  lat_mask;
    logic [31:0] wmask;

    logic [CW-1:0] period_sh, period_act, cnt;
    logic [CW-1:0] duty_sh    [NCH];
    logic [CW-1:0] duty_act   [NCH];
    logic [3:0]    chctrl_sh  [NCH];
    logic [3:0]    chctrl_act [NCH];

    logic           run, force_upd, pending, flag, wrap, load;
    logic           w_period, w_ctrl, w_status, any_shadow_wr;
    logic [NCH-1:0] w_duty, w_chctrl, pwm_nxt;
    logic [31:0]    rdata;
    logic           unused_bits;

    function automatic logic [CW-1:0] merge(input logic [CW-1:0] old, input logic [CW-1:0] data,
                                            input logic [CW-1:0] m);
        return (old & ~m) | (data & m);
    endfunction

    assign in_window   = (add[31:8] == BASE_ADDR[31:8]);
    assign wmask       = {{8{lat_mask[3]}}, {8{lat_mask[2]}}, {8{lat_mask[1]}}, {8{lat_mask[0]}}};
    assign unused_bits = ^{lat_din, wmask};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (wr && in_window)      next_state = WR_WAIT;
                else if (rd && in_window) next_state = RD_WAIT;
            end
            WR_WAIT: if (wr_strobe) next_state = IDLE;
            RD_WAIT: if (rd_strobe) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        wr_start = (state == IDLE) && wr && in_window;
        rd_start = (state == IDLE) && !wr && rd && in_window;
        commit   = (state == WR_WAIT) && wr_strobe;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_busy  <= 1'b0;
            rd_busy  <= 1'b0;
            dout     <= '0;
            lat_off  <= '0;
            lat_din  <= '0;
            lat_mask <= '0;
        end else begin
            wr_busy <= (next_state == WR_WAIT);
            rd_busy <= (next_state == RD_WAIT);
            if (rd_start) dout <= rdata;
            if (wr_start) begin
                lat_off  <= add[7:0];
                lat_din  <= din;
                lat_mask <= mask;
            end
        end
    end

    always_comb begin
        w_period = commit && (lat_off == 8'h00);
        w_ctrl   = commit && (lat_off == 8'h04);
        w_status = commit && (lat_off == 8'h08);
        w_duty   = '0;
        w_chctrl = '0;
        for (int i = 0; i < NCH; i++) begin
            w_duty[i]   = commit && (lat_off == 8'(16 + 8 * i));
            w_chctrl[i] = commit && (lat_off == 8'(20 + 8 * i));
        end
        any_shadow_wr = w_period | (|w_duty) | (|w_chctrl);
    end

    // Reads see the active copy, so software observes what the outputs are really using.
    always_comb begin
        rdata = 32'hDEAD_BEEF;
        case (add[7:0])
            8'h00:   rdata = 32'(period_act);
            8'h04:   rdata = {31'b0, run};
            8'h08:   rdata = {30'b0, flag, pending};
            default: rdata = 32'hDEAD_BEEF;
        endcase
        for (int i = 0; i < NCH; i++) begin
            if (add[7:0] == 8'(16 + 8 * i)) rdata = 32'(duty_act[i]);
            if (add[7:0] == 8'(20 + 8 * i)) rdata = {28'b0, chctrl_act[i]};
        end
    end

    // >= rather than == so a forced load of a shorter period cannot strand cnt above it.
    assign wrap = run && (cnt >= period_act);
    // The shadow write landing on the load edge is not seen here; its pending bit survives.
    assign load = force_upd || (pending && (wrap || !run));

    always_ff @(posedge clk) begin
        if (rst) begin
            run       <= 1'b0;
            force_upd <= 1'b0;
            pending   <= 1'b0;
            cnt       <= '0;
            period_sh <= PERIOD_RST;
            period_act <= PERIOD_RST;
            for (int i = 0; i < NCH; i++) begin
                duty_sh[i]    <= '0;
                duty_act[i]   <= '0;
                chctrl_sh[i]  <= '0;
                chctrl_act[i] <= '0;
            end
        end else begin
            if (w_ctrl && lat_mask[0]) run <= lat_din[0];
            force_upd <= w_ctrl && lat_mask[0] && lat_din[1];

            if (any_shadow_wr) pending <= 1'b1;
            else if (load)     pending <= 1'b0;

            if (!run || wrap) cnt <= '0;
            else              cnt <= cnt + CW'(1);

            if (w_period) period_sh <= merge(period_sh, lat_din[CW-1:0], wmask[CW-1:0]);
            for (int i = 0; i < NCH; i++) begin
                if (w_duty[i])
                    duty_sh[i] <= merge(duty_sh[i], lat_din[CW-1:0], wmask[CW-1:0]);
                if (w_chctrl[i])
                    chctrl_sh[i] <= (chctrl_sh[i] & ~wmask[3:0]) | (lat_din[3:0] & wmask[3:0]);
            end

            if (load) begin
                period_act <= period_sh;
                for (int i = 0; i < NCH; i++) begin
                    duty_act[i]   <= duty_sh[i];
                    chctrl_act[i] <= chctrl_sh[i];
                end
            end
        end
    end

    // Compare in CW+1 bits so P = PERIOD+1 never overflows.
    always_comb begin
        logic [CW:0] p, dx, d, pd, l, c;
        logic        hi;
        p       = {1'b0, period_act} + (CW+1)'(1);
        c       = {1'b0, cnt};
        dx      = '0;
        d       = '0;
        pd      = '0;
        l       = '0;
        hi      = 1'b0;
        pwm_nxt = '0;
        for (int i = 0; i < NCH; i++) begin
            dx = {1'b0, duty_act[i]};
            d  = (dx > p) ? p : dx;
            pd = p - d;
            l  = pd >> 1;
            case (chctrl_act[i][1:0])
                2'b00:   hi = (c < d);
                2'b01:   hi = (c >= l) && (c < l + d);
                default: hi = (c >= pd);
            endcase
            pwm_nxt[i] = (hi ^ chctrl_act[i][2]) & chctrl_act[i][3] & run;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) pwm_out <= '0;
        else     pwm_out <= pwm_nxt;
    end

`ifdef PWM_IRQ_EN
    always_ff @(posedge clk) begin
        if (rst)                                       flag <= 1'b0;
        else if (wrap)                                 flag <= 1'b1;
        else if (w_status && lat_mask[0] && lat_din[1]) flag <= 1'b0;
    end
    assign irq = flag;
`else
    assign flag = 1'b0;
    assign irq  = 1'b0;
    logic unused_status;
    assign unused_status = w_status;
`endif

endmodule

// File: tb/tb_pwm_multichannel.sv
// Directed bench for pwm_multichannel: bus access, alignment patterns, shadow timing, limits, irq.
module tb_pwm_multichannel;

    localparam logic [31:0] BASE = 32'h4000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] add = '0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic        wr_busy, rd_busy;
    logic        wr_strobe = 1'b0;
    logic        rd_strobe = 1'b0;
    logic [3:0]  mask = '0;
    logic [3:0]  pwm_out;
    logic        irq;

    logic [31:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    pwm_multichannel dut (
        .clk(clk), .rst(rst), .add(add), .din(din), .dout(dout),
        .wr(wr), .rd(rd), .wr_busy(wr_busy), .rd_busy(rd_busy),
        .wr_strobe(wr_strobe), .rd_strobe(rd_strobe), .mask(mask),
        .pwm_out(pwm_out), .irq(irq)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // scoreboard
    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic expect_now(input string tag, input logic [31:0] e, input logic [31:0] obs);
        exp_q.push_back(e);
        check(tag, obs);
    endtask

    // drivers: every task starts and ends 1 time unit after a rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] off, input logic [31:0] data, input logic [3:0] m);
        int guard;
        add = BASE + 32'(off);
        din = data;
        mask = m;
        wr = 1'b1;
        tick();
        wr = 1'b0;
        guard = 0;
        while (!wr_busy && guard < 8) begin
            tick();
            guard++;
        end
        if (!wr_busy) begin
            errors++;
            $display("FAIL wr_busy_timeout observed=0 expected=1");
        end
        wr_strobe = 1'b1;
        tick();
        wr_strobe = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [7:0] off, input logic [31:0] e,
                            input logic [31:0] sel);
        int guard;
        exp_q.push_back(e & sel);
        add = BASE + 32'(off);
        rd = 1'b1;
        tick();
        rd = 1'b0;
        guard = 0;
        while (!rd_busy && guard < 8) begin
            tick();
            guard++;
        end
        if (!rd_busy) begin
            errors++;
            $display("FAIL %s_timeout observed=rd_busy=0 expected=1", tag);
        end
        check(tag, dout & sel);
        rd_strobe = 1'b1;
        tick();
        rd_strobe = 1'b0;
    endtask

    task automatic wait_phase(input int k);
        int guard;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (((cyc - t0) % 10) != k && guard < 40);
        if (((cyc - t0) % 10) != k) begin
            errors++;
            $display("FAIL wait_phase observed=%0d expected=%0d", (cyc - t0) % 10, k);
        end
    endtask

    task automatic start_run();
        bus_write(8'h04, 32'h1, 4'hF);
        t0 = cyc;
    endtask

    initial begin
        logic [9:0] pat0, pat1, pat2, pat3;
        logic [3:0] e4;
        int s, per, pc, d;

        pat0 = 10'b0000000111;
        pat1 = 10'b0001111000;
        pat2 = 10'b1111000000;
        pat3 = 10'b0000111111;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        expect_now("rst_dout", 32'h0, dout);
        expect_now("rst_wr_busy", 32'h0, 32'(wr_busy));
        expect_now("rst_rd_busy", 32'h0, 32'(rd_busy));
        expect_now("rst_pwm", 32'h0, 32'(pwm_out));
        expect_now("rst_irq", 32'h0, 32'(irq));
        bus_read("rd_period_rst", 8'h00, 32'd99, 32'hFFFF_FFFF);
        bus_read("rd_unmapped_44", 8'h44, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        bus_read("rd_unmapped_0c", 8'h0C, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        bus_read("rd_duty0_rst", 8'h10, 32'h0, 32'hFFFF_FFFF);

        // out-of-window request is ignored
        add = BASE + 32'h100;
        wr = 1'b1;
        tick();
        wr = 1'b0;
        expect_now("oow_no_busy", 32'h0, 32'(wr_busy));

        // byte enables: only low byte lands
        bus_write(8'h18, 32'h0000_ABCD, 4'b0001);
        tick();
        bus_read("mask_duty1", 8'h18, 32'h0000_00CD, 32'hFFFF_FFFF);

        // four channels: left, centre, right, inverted right
        bus_write(8'h00, 32'd9, 4'hF);
        bus_write(8'h10, 32'd3, 4'hF);
        bus_write(8'h14, 32'h8, 4'hF);
        bus_write(8'h18, 32'd4, 4'hF);
        bus_write(8'h1C, 32'h9, 4'hF);
        bus_write(8'h20, 32'd4, 4'hF);
        bus_write(8'h24, 32'hA, 4'hF);
        bus_write(8'h28, 32'd4, 4'hF);
        bus_write(8'h2C, 32'hE, 4'hF);
        tick();
        bus_read("rd_period_9", 8'h00, 32'd9, 32'hFFFF_FFFF);
        expect_now("pwm_idle_run0", 32'h0, 32'(pwm_out));
        start_run();
        for (int n = 0; n < 20; n++) begin
            tick();
            s = (cyc - t0 - 1) % 10;
            e4 = {pat3[s], pat2[s], pat1[s], pat0[s]};
            expect_now("pwm_align", 32'(e4), 32'(pwm_out));
        end

        // mid-period duty change: takes effect next period
        wait_phase(3);
        bus_write(8'h10, 32'd7, 4'hF);
        pc = (cyc - t0 - 1) / 10;
        for (int n = 0; n < 25; n++) begin
            tick();
            s = (cyc - t0 - 1) % 10;
            per = (cyc - t0 - 1) / 10;
            d = (per <= pc) ? 3 : 7;
            expect_now("pwm_mid_update", 32'(s < d), 32'(pwm_out[0]));
        end

        // write colliding with the wrap: applies one period later
        wait_phase(8);
        bus_write(8'h10, 32'd2, 4'hF);
        pc = (cyc - t0 - 1) / 10;
        bus_read("pending_after_collide", 8'h08, 32'h1, 32'h1);
        for (int n = 0; n < 25; n++) begin
            tick();
            s = (cyc - t0 - 1) % 10;
            per = (cyc - t0 - 1) / 10;
            d = (per <= pc + 1) ? 7 : 2;
            expect_now("pwm_collide", 32'(s < d), 32'(pwm_out[0]));
        end

        // duty limits
        bus_write(8'h10, 32'd0, 4'hF);
        repeat (25) tick();
        for (int n = 0; n < 12; n++) begin
            tick();
            expect_now("duty_zero", 32'h0, 32'(pwm_out[0]));
        end
        bus_write(8'h10, 32'd20, 4'hF);
        repeat (25) tick();
        for (int n = 0; n < 12; n++) begin
            tick();
            expect_now("duty_over", 32'h1, 32'(pwm_out[0]));
        end
        bus_write(8'h10, 32'd1, 4'hF);
        bus_write(8'h00, 32'd0, 4'hF);
        repeat (25) tick();
        for (int n = 0; n < 12; n++) begin
            tick();
            expect_now("period_zero", 32'h1, 32'(pwm_out[0]));
        end

        // restart with a known phase for the interrupt checks
        bus_write(8'h04, 32'h0, 4'hF);
        bus_write(8'h00, 32'd9, 4'hF);
        tick();
        start_run();
`ifdef PWM_IRQ_EN
        wait_phase(0);
        expect_now("irq_after_wrap", 32'h1, 32'(irq));
        wait_phase(2);
        bus_write(8'h08, 32'h2, 4'hF);
        expect_now("irq_w1c", 32'h0, 32'(irq));
        wait_phase(8);
        expect_now("irq_still_clear", 32'h0, 32'(irq));
        bus_write(8'h08, 32'h2, 4'hF);
        expect_now("irq_set_wins", 32'h1, 32'(irq));
`else
        wait_phase(0);
        expect_now("irq_tied_low", 32'h0, 32'(irq));
        bus_read("status_flag_zero", 8'h08, 32'h0, 32'h2);
`endif

        // reset while a write is waiting for its strobe
        add = BASE + 32'h10;
        din = 32'd5;
        mask = 4'hF;
        wr = 1'b1;
        tick();
        wr = 1'b0;
        expect_now("wr_wait_busy", 32'h1, 32'(wr_busy));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_now("rst_mid_wr_busy", 32'h0, 32'(wr_busy));
        expect_now("rst_mid_pwm", 32'h0, 32'(pwm_out));
        expect_now("rst_mid_irq", 32'h0, 32'(irq));
        bus_write(8'h04, 32'h2, 4'hF);
        tick();
        bus_read("rst_mid_duty0", 8'h10, 32'h0, 32'hFFFF_FFFF);
        bus_read("rst_mid_period", 8'h00, 32'd99, 32'hFFFF_FFFF);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
